// File: rtl/servo_pkg.sv
// Shared servo definitions: position codes, scheduler states, step helpers.
// Position codes are common to the move scheduler and the SG90 controller.
// Angle order is 0 < 90 < 180; code 2'b11 is read as the 90 degree home.
package servo_pkg;

  // Position encodings; home (90 degrees) is the all-zero reset value.
  localparam logic [1:0] POS_90  = 2'b00;
  localparam logic [1:0] POS_0   = 2'b01;
  localparam logic [1:0] POS_180 = 2'b10;

  // Scheduler states. IDLE and HOLD both sample new requests.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } sched_state_e;

  // Fold the unused code onto home so every input maps to a real angle.
  function automatic logic [1:0] norm_pos(input logic [1:0] p);
    logic [1:0] r;
    r = (p == 2'b11) ? POS_90 : p;
    return r;
  endfunction

  // Ordinal of an angle: 0 deg -> 0, 90 deg -> 1, 180 deg -> 2.
  function automatic logic [1:0] pos_rank(input logic [1:0] p);
    logic [1:0] r;
    case (norm_pos(p))
      POS_0:   r = 2'd0;
      POS_180: r = 2'd2;
      default: r = 2'd1;
    endcase
    return r;
  endfunction

  // Step direction toward tgt: 1 = clockwise (up the order), 0 = ccw.
  function automatic logic step_is_cw(input logic [1:0] cur, input logic [1:0] tgt);
    logic r;
    r = (pos_rank(tgt) > pos_rank(cur));
    return r;
  endfunction

  // Position after one 90 degree step; saturates at the mechanical ends.
  function automatic logic [1:0] step_pos(input logic [1:0] cur, input logic cw);
    logic [1:0] r;
    case (norm_pos(cur))
      POS_0:   r = cw ? POS_90  : POS_0;
      POS_180: r = cw ? POS_180 : POS_90;
      default: r = cw ? POS_180 : POS_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fixed_prio_arbiter.sv
// Fixed-priority arbiter: one-hot grant to the lowest-index active request.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a losing request is simply not granted this cycle.
module fixed_prio_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the top index down so the lowest set index is what survives.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/servo_move_scheduler.sv
// Servo move scheduler: arbitrates position requests, emits 90 degree step pulses.
// Latency: ack 1 cycle after sampling; first step pulse 2 cycles after sampling.
// Backpressure: requests are only sampled in IDLE/HOLD; others wait holding valid.
module servo_move_scheduler
  import servo_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int SETTLE_CYCLES = 25_000_000,
  parameter int HOLD_CYCLES   = 200_000_000,
  parameter int CNT_W         = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [2*NUM_REQ-1:0]                          req_pos,
  output logic [NUM_REQ-1:0]                            req_ack,
  output logic                                          cw_cmd,
  output logic                                          ccw_cmd,
  output logic [1:0]                                    cur_pos,
  output logic                                          busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Counter reload values; the counter runs N-1 down to 0, i.e. N cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam bit               HOLD_EN     = (HOLD_CYCLES > 0);

  sched_state_e     state;
  sched_state_e     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       target;
  logic [1:0]       target_nxt;
  logic [1:0]       cur_pos_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic             cw_nxt;
  logic             ccw_nxt;
  logic             busy_nxt;
  logic [IDX_W-1:0] gidx_nxt;

  // Arbitration inputs/outputs. A requester whose ack is on the wire this
  // cycle is masked: it is still holding valid while it sees the ack, and
  // must not be granted a second time for the same request.
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [1:0]         sel_pos;

  assign req_eff = req_valid & ~req_ack;

  fixed_prio_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req_eff),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Select the winning requester's target, folding 2'b11 onto home.
  always_comb begin
    sel_pos = POS_90;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_pos = norm_pos(req_pos[2*i +: 2]);
      end
    end
  end

  // Next-state and next-output logic for the move sequencer.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    target_nxt  = target;
    cur_pos_nxt = cur_pos;
    ack_nxt     = '0;
    cw_nxt      = 1'b0;
    ccw_nxt     = 1'b0;
    gidx_nxt    = grant_idx;

    case (state)
      // Sampling states: a request always wins, even over an expiring hold.
      ST_IDLE, ST_HOLD: begin
        if (arb_any) begin
          ack_nxt    = arb_gnt;
          gidx_nxt   = arb_idx;
          target_nxt = sel_pos;
          if (sel_pos != cur_pos) begin
            state_nxt = ST_STEP;
          end else if ((sel_pos != POS_90) && HOLD_EN) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (state == ST_HOLD) begin
          if (cnt == '0) begin
            // Hold expired: head home without acking anyone.
            target_nxt = POS_90;
            state_nxt  = (cur_pos != POS_90) ? ST_STEP : ST_IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end

      // One pulse per visit; position tracking moves on the same edge.
      ST_STEP: begin
        cw_nxt      = step_is_cw(cur_pos, target);
        ccw_nxt     = ~cw_nxt;
        cur_pos_nxt = step_pos(cur_pos, cw_nxt);
        cnt_nxt     = SETTLE_LOAD;
        state_nxt   = ST_SETTLE;
      end

      // Mechanical settle; requests are deliberately not sampled here.
      ST_SETTLE: begin
        if (cnt == '0) begin
          if (cur_pos != target) begin
            state_nxt = ST_STEP;
          end else if ((target != POS_90) && HOLD_EN) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers; reset lands on home to match the servo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      target    <= POS_90;
      cur_pos   <= POS_90;
      req_ack   <= '0;
      cw_cmd    <= 1'b0;
      ccw_cmd   <= 1'b0;
      busy      <= 1'b0;
      grant_idx <= '0;
    end else begin
      cnt       <= cnt_nxt;
      target    <= target_nxt;
      cur_pos   <= cur_pos_nxt;
      req_ack   <= ack_nxt;
      cw_cmd    <= cw_nxt;
      ccw_cmd   <= ccw_nxt;
      busy      <= busy_nxt;
      grant_idx <= gidx_nxt;
    end
  end

endmodule

// File: doc/servo_move_scheduler.md
Name: servo_move_scheduler

Overview:
Arbitrates servo-position requests from several requesters: bay entry sensor, bay exit sensor and Bluetooth command decoder. Issues single-step cw_cmd/ccw_cmd pulses to the downstream SG90 servo controller, and inserts a mechanical settle interval between steps. After a non-home move it holds the position for a timed interval, then automatically returns the servo to the 90° home position. It tracks the servo position itself, so the servo controller needs no feedback path.

Parameters:
NUM_REQ, 3, number of requesters; index 0 has the highest priority.
SETTLE_CYCLES, 25_000_000, wait after each step pulse (0.5 s at 50 MHz); must be >= 1.
HOLD_CYCLES, 200_000_000, hold time at a non-90° target before the auto-return (4 s); 0 disables the auto-return.
CNT_W, 32, width of the settle/hold counter; must hold max(SETTLE_CYCLES, HOLD_CYCLES).

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held until ack
req_pos  in  2*NUM_REQ  target position of requester i, in bits [2i+1:2i]
req_ack  out  NUM_REQ  one-cycle pulse: request i has been accepted
cw_cmd  out  1  one-cycle pulse: step clockwise by 90°
ccw_cmd  out  1  one-cycle pulse: step counter-clockwise by 90°
cur_pos  out  2  tracked servo position
busy  out  1  high in every state except IDLE
grant_idx  out  $clog2(NUM_REQ) (min 1)  index of the last accepted requester

Behaviour:
- Position encoding: POS_90=2'b00, POS_0=2'b01, POS_180=2'b10. Code 2'b11 is treated as POS_90.
- Angle order is 0 < 90 < 180. cw moves one step up the order, ccw moves one step down.
- Reset values: state=IDLE, cur_pos=POS_90, all outputs 0, grant_idx=0, counter=0, target=POS_90.
- All outputs are registered.
- States are IDLE, STEP, SETTLE, HOLD.
- IDLE (sampling state):
  - If any req_valid is high, grant the lowest set index i.
  - Next cycle: req_ack[i]=1, grant_idx=i, target=req_pos[i].
  - The state goes to STEP if target != cur_pos.
  - Otherwise it goes to HOLD if target != POS_90 and HOLD_CYCLES > 0, else back to IDLE.
  - Latency from req_valid to req_ack is 1 cycle.
- STEP (lasts exactly 1 cycle):
  - In the next cycle, cw_cmd=1 if target is higher than cur_pos, else ccw_cmd=1. The same edge updates cur_pos by one step.
  - The counter is loaded with SETTLE_CYCLES-1 and the state goes to SETTLE.
  - cw_cmd and ccw_cmd are never high together.
- SETTLE:
  - The counter decrements; requests are ignored.
  - When counter=0: go to STEP if cur_pos != target.
  - Otherwise go to HOLD with the counter loaded to HOLD_CYCLES-1, if target != POS_90 and HOLD_CYCLES > 0.
  - Otherwise go to IDLE.
- HOLD (sampling state, same arbitration as IDLE):
  - A new request preempts the hold (retarget) and is acked exactly as in IDLE.
  - When counter=0 with no request: target=POS_90, state goes to STEP (auto-return). No ack is issued.
- Moving 0°→180° or 180°→0° takes two STEP/SETTLE cycles. The total is 2 pulses separated by SETTLE_CYCLES+1 cycles.
- A losing requester keeps req_valid high and is served at the next sampling state. There is no starvation guard: priority is fixed by design.
- A request deasserted before ack is forgotten; no request memory is kept.
- If a request arrives in the same cycle the hold expires, the request wins and the auto-return is skipped.
- Reset mid-move forces IDLE and cur_pos=POS_90. The servo controller shares rst_n and also resets to 90°, so tracking stays consistent.

Decomposition:
- Package servo_pkg: POS_0/POS_90/POS_180 encodings, state encodings, and a step-direction function.
- Shared with the servo controller: servo_pkg is also used by the SG90 servo controller, so position codes are shared.
- Sub-module fixed_prio_arbiter: a parameterised NUM_REQ one-hot lowest-index grant, purely combinational.
- The counter and FSM stay in the top module.

Test Plan:
- Reset, then req_valid[1]=1 with pos=POS_180 → req_ack[1] one cycle later; cw_cmd pulses once; cur_pos=10.
  - With SETTLE=10 and HOLD=50: after 10 settle cycles and 50 hold cycles, ccw_cmd pulses once and cur_pos=00.
- From POS_0, a request for POS_180 → exactly two cw_cmd pulses, 11 cycles apart. No ccw_cmd pulse.
- req_valid=3'b110 in the same cycle → req_ack=3'b010 first, grant_idx=1. Requester 2 is acked after the move completes; a target equal to cur_pos gives no step pulse.
- During HOLD at POS_180, requester 0 asks for POS_0 → immediate ack, two ccw_cmd pulses, and a new hold at POS_0. There is no pulse back to 90 first.
- A request arriving during SETTLE is ignored until SETTLE ends. req_valid pulsed for only 1 cycle during SETTLE gives no ack.
- rst_n dropped one cycle after a cw_cmd pulse → all outputs 0, cur_pos=00, busy=0 asynchronously. After release the scheduler accepts new requests normally.
